// File: rtl/pipe_addsub.sv
// Pipelined add/sub: WIDTH bits split into STAGES carry segments with valid/ready on both sides.
// Optional `PIPE_ADDSUB_SAT_EN builds unsigned saturation into the final stage.
module pipe_addsub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CH = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   logic [STAGES-1:0] v_q, c_q, adv, ld, vin;
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic              ovf_q;

   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [WIDTH-1:0]  s_nx [STAGES];
   logic [CH:0]       add_w [STAGES];
   logic [STAGES-1:0] c_in, c_nx;
   logic [WIDTH-1:0]  sum_nx;
   logic              ovf_nx;
`ifdef PIPE_ADDSUB_SAT_EN
   logic [STAGES-1:0] sub_q, sub_in;
`endif

   // Ready ripples back from out_ready; an empty stage accepts regardless of downstream.
   always_comb begin
      logic ok;
      adv = '0;
      ld  = '0;
      ok  = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = v_q[k] && ok;
         ld[k]  = !v_q[k] || ok;
         ok     = ld[k];
      end
   end

   always_comb begin
      vin    = '0;
      vin[0] = in_valid;
      for (int k = 1; k < STAGES; k++) vin[k] = adv[k-1];
   end

   assign in_ready = ld[0];

   always_comb begin
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in    = '0;
      c_in[0] = sub ^ cin;
      s_in[0] = '0;
`ifdef PIPE_ADDSUB_SAT_EN
      sub_in    = '0;
      sub_in[0] = sub;
`endif
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
         s_in[k] = s_q[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
         sub_in[k] = sub_q[k-1];
`endif
      end
      c_nx = '0;
      // Each finished chunk enters at the top so chunk 0 lands at bit 0 after the last stage.
      for (int k = 0; k < STAGES; k++) begin
         add_w[k] = {1'b0, a_in[k][CH-1:0]} + {1'b0, b_in[k][CH-1:0]} + {{CH{1'b0}}, c_in[k]};
         s_nx[k]  = (s_in[k] >> CH) | (WIDTH'(add_w[k][CH-1:0]) << (WIDTH - CH));
         c_nx[k]  = add_w[k][CH];
      end
   end

   always_comb begin
      sum_nx = s_nx[L];
      ovf_nx = (a_in[L][CH-1] == b_in[L][CH-1]) && (add_w[L][CH-1] != a_in[L][CH-1]);
`ifdef PIPE_ADDSUB_SAT_EN
      if (!sub_in[L] && c_nx[L])
         sum_nx = '1;
      else if (sub_in[L] && !c_nx[L])
         sum_nx = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
         sub_q <= '0;
`endif
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= '0;
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               v_q[k] <= vin[k];
               if (vin[k]) begin
                  s_q[k] <= (k == L) ? sum_nx : s_nx[k];
                  c_q[k] <= c_nx[k];
                  a_q[k] <= a_in[k] >> CH;
                  b_q[k] <= b_in[k] >> CH;
`ifdef PIPE_ADDSUB_SAT_EN
                  sub_q[k] <= sub_in[k];
`endif
               end
            end
         end
         if (ld[L] && vin[L]) ovf_q <= ovf_nx;
      end
   end

   assign out_valid = v_q[L];
   assign sum       = s_q[L];
   assign cout      = c_q[L];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=8, STAGES=2): directed corners, backpressure,
// mid-flight reset and a randomized run against an arithmetic reference queue.
module tb_pipe_addsub;

   localparam int W = 8;
   localparam int S = 2;
`ifdef PIPE_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int           n_chk = 0;
   int           n_pass = 0;
   logic [W+1:0] exp_q[$];
   logic         fin;

   pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic; signed overflow judged by range of the true signed sum.
   function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                          input logic s, input logic c);
      logic [W-1:0] bp;
      int unsigned  r;
      int           sr;
      logic [W-1:0] rs;
      logic         co, ov;
      bp = s ? ~bb : bb;
      r  = int'(aa) + int'(bp) + int'(s ^ c);
      sr = int'($signed(aa)) + int'($signed(bp)) + int'(s ^ c);
      ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      co = r[W];
      rs = r[W-1:0];
      if (SAT && !s && co) rs = '1;
      if (SAT && s && !co) rs = '0;
      return {ov, co, rs};
   endfunction

   // One cycle: drive at negedge, sample 1 time unit later, score the handshakes due at the next posedge.
   task automatic cyc(input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic s, input logic c, input logic orr, output logic fired);
      logic [W+1:0] e;
      @(negedge clk);
      in_valid = iv; a = aa; b = bb; sub = s; cin = c; out_ready = orr;
      #1;
      fired = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("q_sum", 32'(sum), 32'(e[W-1:0]));
            check("q_cout", 32'(cout), 32'(e[W]));
            check("q_ovf", 32'(ovf), 32'(e[W+1]));
         end
      end
      if (fired) exp_q.push_back(model(aa, bb, s, c));
   endtask

   task automatic dir(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic s, input logic c,
                      input logic [W-1:0] esum, input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; a = aa; b = bb; sub = s; cin = c; out_ready = 1'b1;
      #1 check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         #1 lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(S));
      check({tag, "_sum"}, 32'(sum), 32'(esum));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   logic [W-1:0] bp_op[4];
   logic [W-1:0] ra, rb;
   logic         rs, rc, riv;

   initial begin
      int idx, nops, cycles, d;

      #12;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_sum", 32'(sum), 32'(0));
      check("rst_cout", 32'(cout), 32'(0));
      check("rst_ovf", 32'(ovf), 32'(0));
      rst_n = 1'b1;
      #1 check("rst_in_ready", 32'(in_ready), 32'(1));

      dir("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0);
      dir("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      dir("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
      dir("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b0);
      dir("add_cin",   8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);

      bp_op[0] = 8'h01; bp_op[1] = 8'h02; bp_op[2] = 8'h03; bp_op[3] = 8'h04;
      idx = 0;
      for (int t = 0; t < 10; t++) begin
         cyc(idx < 4, bp_op[idx < 4 ? idx : 0], bp_op[idx < 4 ? idx : 0], 1'b0, 1'b0, t >= 4, fin);
         if (fin) idx++;
         if (t == 2 || t == 3) begin
            check("bp_in_ready_low", 32'(in_ready), 32'(0));
            check("bp_held_valid", 32'(out_valid), 32'(1));
            check("bp_held_sum", 32'(sum), 32'(8'h02));
            check("bp_held_count", 32'(exp_q.size()), 32'(2));
         end
         if (t >= 4 && t <= 7) check("bp_stream_valid", 32'(out_valid), 32'(1));
      end
      check("bp_all_accepted", 32'(idx), 32'(4));

      @(negedge clk);
      in_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      a = 8'h33; b = 8'h44;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      check("rst_mid_pre_valid", 32'(out_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 32'(out_valid), 32'(0));
      check("rst_mid_sum", 32'(sum), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fin);
         check("rst_no_stale", 32'(out_valid), 32'(0));
      end

      nops = 0; cycles = 0; riv = 1'b0;
      ra = '0; rb = '0; rs = 1'b0; rc = 1'b0;
      while (nops < 10000 && cycles < 60000) begin
         if (!riv) begin
            riv = ($urandom_range(0, 3) != 0);
            ra  = W'($urandom);
            rb  = W'($urandom);
            rs  = 1'($urandom);
            rc  = ($urandom_range(0, 3) == 0);
         end
         cyc(riv, ra, rb, rs, rc, $urandom_range(0, 3) != 0, fin);
         if (fin) begin
            nops++;
            riv = 1'b0;
         end
         cycles++;
      end
      check("rand_ops_issued", 32'(nops), 32'(10000));
      d = 0;
      while (exp_q.size() > 0 && d < 50) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fin);
         d++;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fin);
      check("drain_out_valid", 32'(out_valid), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
